pswd_entry: RTL and testbench

Keypad front end for the parking gate controller. It collects decimal digit key presses while a car waits at the front sensor and assembles them into an 8-bit password value. It presents that value, qualified by a valid strobe, to the downstream gate state machine's `pswd` input. Malformed entries are rejected with a lockout, and stalled entries time out.

---
 rtl/pswd_pkg.sv | 16 +
 rtl/pswd_entry_cyc_timer.sv | 27 ++
 rtl/pswd_entry.sv | 150 +++++++++++++++
 tb/tb_pswd_entry.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pswd_pkg.sv
// Shared types and constants for the parking gate keypad front end.
// State encoding, key codes and the password value limit.
package pswd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_HOLD,
        S_ERROR
    } state_t;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [7:0] PSWD_LIMIT = 8'd255;

endpackage

// File: rtl/pswd_entry_cyc_timer.sv
// Loadable saturating down-counter shared by the timeout, hold and lockout.
// Ports: clk, rst (async high), load, load_val[W-1:0], done (count == 0).
module cyc_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/pswd_entry.sv
// Keypad digit collector: builds an 8-bit password and presents it with a strobe.
// Ports: clk, rst, arm, key_valid, key_code[3:0] in; pswd[7:0], pswd_valid,
// entry_busy, digit_cnt[1:0], err out (all registered).
module pswd_entry
    import pswd_pkg::*;
#(
    parameter int MAX_DIGITS = 3,
    parameter int TIMEOUT    = 1000,
    parameter int HOLD_CYC   = 16,
    parameter int ERR_CYC    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] pswd,
    output logic       pswd_valid,
    output logic       entry_busy,
    output logic [1:0] digit_cnt,
    output logic       err
);

    localparam int TMAX_A = (TIMEOUT > HOLD_CYC) ? TIMEOUT : HOLD_CYC;
    localparam int TMAX   = (TMAX_A > ERR_CYC) ? TMAX_A : ERR_CYC;
    localparam int TW     = $clog2(TMAX);

    state_t        state;
    logic [9:0]    acc;
    logic [9:0]    acc_next;
    logic          is_digit;
    logic          is_clear;
    logic          is_enter;
    logic          accepted;
    logic          reject;
    logic          t_load;
    logic [TW-1:0] t_val;
    logic          t_done;

    // Only three digits ever accumulate, so acc <= 99 before the last one
    // and acc*10 + d cannot wrap 10 bits.
    assign acc_next = acc * 10'd10 + {6'd0, key_code};
    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_clear = key_valid && (key_code == KEY_CLEAR);
    assign is_enter = key_valid && (key_code == KEY_ENTER);
    assign accepted = is_digit || is_clear || is_enter;
    assign reject   = is_digit &&
                      ((acc_next > {2'd0, PSWD_LIMIT}) ||
                       (digit_cnt == 2'(MAX_DIGITS)));

    // Timer reload mirrors the FSM transitions below.
    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        unique case (state)
            S_IDLE: begin
                if (arm) begin
                    t_load = 1'b1;
                    t_val  = TW'(TIMEOUT - 1);
                end
            end
            S_ENTRY: begin
                if (arm && !t_done && accepted) begin
                    t_load = 1'b1;
                    if (reject) begin
                        t_val = TW'(ERR_CYC - 1);
                    end else if (is_enter && digit_cnt != 2'd0) begin
                        t_val = TW'(HOLD_CYC - 1);
                    end else begin
                        t_val = TW'(TIMEOUT - 1);
                    end
                end
            end
            default: ;
        endcase
    end

    cyc_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (t_load),
        .load_val(t_val),
        .done    (t_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            digit_cnt  <= '0;
            pswd       <= '0;
            pswd_valid <= 1'b0;
            entry_busy <= 1'b0;
            err        <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (arm) begin
                        state      <= S_ENTRY;
                        entry_busy <= 1'b1;
                    end
                end
                S_ENTRY: begin
                    if (!arm || t_done) begin
                        state      <= S_IDLE;
                        entry_busy <= 1'b0;
                        acc        <= '0;
                        digit_cnt  <= '0;
                    end else if (reject) begin
                        state      <= S_ERROR;
                        entry_busy <= 1'b0;
                        err        <= 1'b1;
                        acc        <= '0;
                        digit_cnt  <= '0;
                    end else if (is_digit) begin
                        acc       <= acc_next;
                        digit_cnt <= digit_cnt + 2'd1;
                    end else if (is_clear) begin
                        acc       <= '0;
                        digit_cnt <= '0;
                    end else if (is_enter && digit_cnt != 2'd0) begin
                        state      <= S_HOLD;
                        entry_busy <= 1'b0;
                        pswd       <= acc[7:0];
                        pswd_valid <= 1'b1;
                        acc        <= '0;
                        digit_cnt  <= '0;
                    end
                end
                S_HOLD: begin
                    if (!arm || t_done) begin
                        state      <= S_IDLE;
                        pswd       <= '0;
                        pswd_valid <= 1'b0;
                    end
                end
                S_ERROR: begin
                    if (t_done) begin
                        state <= S_IDLE;
                        err   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pswd_entry.sv
// Directed bench for pswd_entry with hand-computed expectations.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_pswd_entry;

    logic       clk;
    logic       rst;
    logic       arm;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] pswd;
    logic       pswd_valid;
    logic       entry_busy;
    logic [1:0] digit_cnt;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    pswd_entry dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .key_valid (key_valid),
        .key_code  (key_code),
        .pswd      (pswd),
        .pswd_valid(pswd_valid),
        .entry_busy(entry_busy),
        .digit_cnt (digit_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic wait_entry(input string tag);
        int n;
        n = 0;
        while (!entry_busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(entry_busy), 1);
    endtask

    // Counts cycles pswd_valid stays high from the current sample point.
    task automatic hold_len(input string tag, input int exp);
        int n;
        n = 0;
        while (pswd_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, exp);
    endtask

    initial begin
        int n;
        int seen;
        rst       = 1'b1;
        arm       = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pswd", int'(pswd), 0);
        chk("rst_valid", int'(pswd_valid), 0);
        chk("rst_busy", int'(entry_busy), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_noarm", int'(entry_busy), 0);

        // 2,5,3 -> 253
        arm = 1'b1;
        @(negedge clk);
        chk("arm_busy", int'(entry_busy), 1);
        press(4'd2);
        press(4'd5);
        press(4'd3);
        chk("cnt3", int'(digit_cnt), 3);
        press(4'hB);
        chk("p253", int'(pswd), 253);
        chk("v253", int'(pswd_valid), 1);
        hold_len("hold253", 16);
        chk("p253_off", int'(pswd), 0);
        chk("idle_after_hold", int'(entry_busy), 0);
        @(negedge clk);
        chk("reentry", int'(entry_busy), 1);

        // 1,9,4 -> 194
        press(4'd1);
        press(4'd9);
        press(4'd4);
        press(4'hB);
        chk("p194", int'(pswd), 194);
        hold_len("hold194", 16);
        wait_entry("entry_b");

        // 2,5,6 -> overflow lockout
        press(4'd2);
        press(4'd5);
        press(4'd6);
        chk("err256", int'(err), 1);
        n = 0;
        seen = 0;
        while (err && n < 100) begin
            if (pswd_valid) seen = 1;
            @(negedge clk);
            n++;
        end
        chk("errlen", n, 32);
        chk("no_valid_err", seen, 0);
        wait_entry("entry_c");

        // Four digits -> lockout
        press(4'd1);
        press(4'd2);
        press(4'd3);
        chk("err_3dig", int'(err), 0);
        press(4'd4);
        chk("err_4dig", int'(err), 1);
        chk("cnt_err", int'(digit_cnt), 0);
        n = 0;
        while (err && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("errlen2", n, 32);
        wait_entry("entry_d");

        // 7, CLEAR, 4, 2 -> 42
        press(4'd7);
        press(4'hA);
        chk("clr_cnt", int'(digit_cnt), 0);
        press(4'd4);
        press(4'd2);
        press(4'hB);
        chk("p42", int'(pswd), 42);
        hold_len("hold42", 16);
        wait_entry("entry_e");

        // ENTER with no digits
        press(4'hB);
        chk("enter0_busy", int'(entry_busy), 1);
        chk("enter0_valid", int'(pswd_valid), 0);

        // Timeout after one digit
        press(4'd9);
        repeat (999) @(negedge clk);
        chk("to_before", int'(entry_busy), 1);
        chk("to_cnt_before", int'(digit_cnt), 1);
        @(negedge clk);
        chk("to_busy", int'(entry_busy), 0);
        chk("to_cnt", int'(digit_cnt), 0);
        chk("to_err", int'(err), 0);
        @(negedge clk);
        chk("to_reentry", int'(entry_busy), 1);

        // Ignored codes do not restart the timeout
        for (int i = 0; i < 99; i++) begin
            key_valid = 1'b1;
            key_code  = 4'hE;
            @(negedge clk);
            key_valid = 1'b0;
            key_code  = 4'h0;
            repeat (9) @(negedge clk);
        end
        chk("ign_before", int'(entry_busy), 1);
        repeat (10) @(negedge clk);
        chk("ign_timeout", int'(entry_busy), 0);
        wait_entry("entry_f");

        // arm drop mid-entry
        press(4'd1);
        press(4'd2);
        chk("cnt2", int'(digit_cnt), 2);
        arm = 1'b0;
        @(negedge clk);
        chk("drop_busy", int'(entry_busy), 0);
        chk("drop_cnt", int'(digit_cnt), 0);
        arm = 1'b1;
        @(negedge clk);
        chk("rearm", int'(entry_busy), 1);
        press(4'd5);
        press(4'hB);
        chk("p5", int'(pswd), 5);
        chk("v5", int'(pswd_valid), 1);

        // Async reset mid-HOLD
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", int'(pswd_valid), 0);
        chk("arst_pswd", int'(pswd), 0);
        #1 rst = 1'b0;
        chk("arst_busy", int'(entry_busy), 0);
        @(negedge clk);
        chk("arst_entry", int'(entry_busy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
